// File: rtl/uart_rx_if.sv
// Purpose: receiver-side bundle: serial line in, recovered word, strobe and status out.
// Latency: none, wiring only.
// Backpressure: none; rx_valid is a one-cycle strobe and the sink must take it.
interface uart_rx_if #(
    parameter int DW = 8
);
    logic          rx;
    logic [DW-1:0] data_out;
    logic          rx_valid;
    logic          frame_err;
    logic          busy;
`ifdef UART_RX_PARITY_EN
    logic          parity_err;
`endif

    // Receiver side: samples the line and drives the word and status.
    modport slave (
        input  rx,
        output data_out, rx_valid, frame_err, busy
`ifdef UART_RX_PARITY_EN
        , output parity_err
`endif
    );

    // Line driver and word consumer side.
    modport master (
        output rx,
        input  data_out, rx_valid, frame_err, busy
`ifdef UART_RX_PARITY_EN
        , input parity_err
`endif
    );
endinterface

// File: rtl/uart_rx.sv
// Purpose: UART receive deserializer (start, DW data bits LSB first, optional even parity, stop).
// Latency: CLKS_PER_BIT/2 + (DW+1)*CLKS_PER_BIT + 1 cycles from rx_s low to rx_valid (+CLKS_PER_BIT with parity, +2 from rx).
// Backpressure: none; one-cycle rx_valid strobe. Build macro UART_RX_PARITY_EN adds the parity bit and parity_err.
module uart_rx #(
    parameter int DW           = 8,
    parameter int CLKS_PER_BIT = 434
) (
    input  logic      clk,
    input  logic      nrst,
    uart_rx_if.slave  bus
);
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int NW = (DW > 1) ? $clog2(DW) : 1;
    localparam logic [BW-1:0] HALF_CNT = BW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] FULL_CNT = BW'(CLKS_PER_BIT - 1);
    localparam logic [NW-1:0] LAST_BIT = NW'(DW - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        BRK
    } state_t;

    state_t        state;
    logic          rx_m;
    logic          rx_s;
    logic [BW-1:0] baud;
    logic [NW-1:0] bitn;
    logic [DW-1:0] sr;
    logic [DW-1:0] data_q;
    logic          valid_q;
    logic          ferr_q;
    logic          busy_q;
`ifdef UART_RX_PARITY_EN
    logic          par;
    logic          perr_q;
`endif

    assign bus.data_out  = data_q;
    assign bus.rx_valid  = valid_q;
    assign bus.frame_err = ferr_q;
    assign bus.busy      = busy_q;
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err = perr_q;
`endif

    // Two-flop synchronizer for the asynchronous line; idles high so reset does not fake a start bit.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= bus.rx;
            rx_s <= rx_m;
        end
    end

    // Frame FSM: mid-bit sampling off the baud counter, right-shift reassembly, registered outputs.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state   <= IDLE;
            baud    <= '0;
            bitn    <= '0;
            sr      <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par     <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state  <= START;
                        baud   <= '0;
                        busy_q <= 1'b1;
                    end
                end
                START: begin
                    if (baud == HALF_CNT) begin
                        if (!rx_s) begin
                            // Genuine start bit: the previous frame's status is now stale.
                            state  <= DATA;
                            baud   <= '0;
                            bitn   <= '0;
                            ferr_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
                            par    <= 1'b0;
                            perr_q <= 1'b0;
`endif
                        end else begin
                            // Glitch shorter than half a bit: ignore, keep status.
                            state  <= IDLE;
                            busy_q <= 1'b0;
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                DATA: begin
                    if (baud == FULL_CNT) begin
                        baud <= '0;
                        sr   <= {rx_s, sr[DW-1:1]};
`ifdef UART_RX_PARITY_EN
                        par  <= par ^ rx_s;
`endif
                        if (bitn == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end else begin
                            bitn <= bitn + 1'b1;
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (baud == FULL_CNT) begin
                        baud  <= '0;
                        state <= STOP;
                        // Even parity: data bits plus parity bit must XOR to zero.
                        if (par ^ rx_s) begin
                            perr_q <= 1'b1;
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (baud == FULL_CNT) begin
                        baud <= '0;
                        if (rx_s) begin
                            data_q  <= sr;
                            valid_q <= 1'b1;
                            state   <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            ferr_q <= 1'b1;
                            state  <= BRK;
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                BRK: begin
                    // Held-low line (break) must return high before a new start can be seen.
                    if (rx_s) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end
endmodule
